mod3_serial_residue: RTL and testbench
======================================

MOD3_SERIAL_RESIDUE -- requirements
Module: mod3_serial_residue

Interface
REQ-001 The block SHALL have parameter MAX_BITS, default 32: maximum bits per frame before forced termination.
REQ-002 The block SHALL have port Clk  input  1  sole clock; all state changes on rising edge.
REQ-003 The block SHALL have port RstN  input  1  reset; synchronous, active-low.
REQ-004 The block SHALL have port BitIn  input  1  serial operand bit, MSB first.
REQ-005 The block SHALL have port BitValid  input  1  BitIn/BitLast valid this cycle.
REQ-006 The block SHALL have port BitLast  input  1  marks the final bit of a frame.
REQ-007 The block SHALL have port BitReady  output  1  block accepts a bit this cycle.
REQ-008 The block SHALL have port ModOut  output  3  one-hot residue: 001=0, 010=1, 100=2.
REQ-009 The block SHALL have port OutValid  output  1  ModOut/OutErr hold a completed frame result.
REQ-010 The block SHALL have port OutReady  input  1  consumer takes the result.
REQ-011 The block SHALL have port OutErr  output  1  frame was force-terminated at MAX_BITS.
REQ-012 The block SHALL have port BitCount  output  $clog2(MAX_BITS+1)  bits accepted in the current or just-completed frame.

Function
REQ-013 The block SHALL have exactly two states: ACCUM (BitReady=1, OutValid=0) and DONE (BitReady=0, OutValid=1).
REQ-014 A bit SHALL be accepted only on a cycle with BitValid=1 and BitReady=1; BitIn and BitLast SHALL be ignored on all other cycles.
REQ-015 On each accepted bit, the residue register r SHALL update to (2r + BitIn) mod 3: 001->{0:001,1:010}; 010->{0:100,1:001}; 100->{0:010,1:100}.
REQ-016 ModOut SHALL always drive r; r SHALL be exactly one-hot at all times, and no other encoding SHALL ever appear on it.
REQ-017 BitCount SHALL increment by 1 per accepted bit and SHALL saturate at MAX_BITS.
REQ-018 An accepted bit with BitLast=1 SHALL move ACCUM->DONE, so OutValid=1 with the final residue in the cycle after acceptance (latency 1), with OutErr=0.
REQ-019 An accepted bit with BitLast=0 that brings BitCount to MAX_BITS SHALL move ACCUM->DONE with OutErr=1; the residue SHALL include that bit.
REQ-020 If the MAX_BITS-th accepted bit also has BitLast=1, OutErr SHALL be 0.
REQ-021 In DONE, ModOut, OutErr and BitCount SHALL remain stable until OutValid=1 and OutReady=1 occur together.
REQ-022 In the cycle after that handshake: the state SHALL be ACCUM, r SHALL be 001, BitCount SHALL be 0, and OutErr SHALL be 0.
REQ-023 BitReady SHALL be 0 in DONE, including in the handshake cycle, so no bit is accepted while a result is pending (no bit is dropped or merged across frames).
REQ-024 A zero-length frame SHALL be impossible; a result is produced only after at least one accepted bit.

Reset
REQ-025 While RstN=0 at a rising edge, the block SHALL enter ACCUM with r=001 (ModOut=001), BitCount=0, OutValid=0, OutErr=0 and BitReady=1 on the next cycle.
REQ-026 Reset SHALL override any in-flight frame or pending result, discarding it with no output produced.
REQ-027 Outputs SHALL be registered or decoded from registered state only; there SHALL be no combinational path from BitValid to BitReady or from OutReady to OutValid.

Structure
REQ-028 The shared package mod3_pkg SHALL hold constants MOD3_ZERO=001, MOD3_ONE=010, MOD3_TWO=100 and the state enum {ACCUM, DONE}.
REQ-029 The residue step SHALL be a combinational sub-module mod3_step(r, bit) -> r' that doubles r (swap the one-hot bits for 1 and 2) and then adds bit in one-hot form.

Verification
REQ-030 Frame 1,0,1 (value 5) with OutReady=1: ModOut=100 and OutValid=1 exactly one cycle after the last bit; BitCount=3; OutErr=0.
REQ-031 Frame 1,1,0 (value 6), then frame 1 (value 1) back-to-back: results 001 then 010; the second frame's first bit is accepted no earlier than the cycle after the first handshake.
REQ-032 Backpressure: value 7 (1,1,1), OutReady=0 for 5 cycles: ModOut=010, OutValid=1, BitReady=0 held stable for all 5 cycles; BitValid pulses during that time are ignored.
REQ-033 MAX_BITS=4, bits 1,1,1,1,1 without BitLast: DONE after the 4th bit with ModOut=001 (value 15), OutErr=1 and BitCount=4; the 5th bit is not accepted until after the handshake.
REQ-034 Reset mid-frame after bits 1,0: next cycle ModOut=001, BitCount=0, OutValid=0; then frame 1,0 yields 100.
REQ-035 Random frames of 1..MAX_BITS bits with random BitValid/OutReady gaps: ModOut equals the binary value mod 3 for every frame, and ModOut is always one-hot.

Source files
------------

// File: rtl/mod3_pkg.sv
// mod3_pkg
// Shared definitions for the serial mod-3 residue block.
//   MOD3_ZERO/ONE/TWO : one-hot residue encodings (bit index == residue value)
//   state_e           : frame controller states, ACCUM (taking bits) and DONE
//                       (holding a finished result for the consumer)
package mod3_pkg;

  localparam logic [2:0] MOD3_ZERO = 3'b001;
  localparam logic [2:0] MOD3_ONE  = 3'b010;
  localparam logic [2:0] MOD3_TWO  = 3'b100;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

endpackage

// File: rtl/mod3_step.sv
// mod3_step
// Combinational residue update: rOut = (2*rIn + bitIn) mod 3, everything in
// one-hot form so the result can never leave the three legal codes.
//   rIn_i   : current one-hot residue
//   bitIn_i : incoming serial bit
//   rOut_o  : next one-hot residue
module mod3_step
  import mod3_pkg::*;
(
  input  logic [2:0] rIn_i,
  input  logic       bitIn_i,
  output logic [2:0] rOut_o
);

  logic [2:0] doubled;
  logic [2:0] plusOne;

  // Doubling mod 3 maps 0->0, 1->2, 2->1, which in one-hot is just swapping
  // the bits for residues 1 and 2.
  assign doubled = {rIn_i[1], rIn_i[2], rIn_i[0]};

  // Adding one rotates the one-hot code up by a position (2 wraps to 0).
  assign plusOne = {doubled[1], doubled[0], doubled[2]};

  assign rOut_o = bitIn_i ? plusOne : doubled;

endmodule

// File: rtl/mod3_serial_residue.sv
// mod3_serial_residue
// Accepts an MSB-first serial operand and reports its value mod 3 as a
// one-hot code once the frame ends (BitLast) or is cut off at MAX_BITS.
//   Clk, RstN          : clock and synchronous active-low reset
//   BitIn/BitLast      : serial bit and end-of-frame marker, qualified by BitValid
//   BitReady           : high while a frame is being accumulated
//   ModOut             : one-hot residue (001=0, 010=1, 100=2)
//   OutValid/OutReady  : result handshake; result held until taken
//   OutErr             : frame was force-terminated at MAX_BITS
//   BitCount           : bits accepted in the current or just-completed frame
module mod3_serial_residue
  import mod3_pkg::*;
#(
  parameter int MAX_BITS = 32
)
(
  input  logic                           Clk,
  input  logic                           RstN,
  input  logic                           BitIn,
  input  logic                           BitValid,
  input  logic                           BitLast,
  output logic                           BitReady,
  output logic [2:0]                     ModOut,
  output logic                           OutValid,
  input  logic                           OutReady,
  output logic                           OutErr,
  output logic [$clog2(MAX_BITS+1)-1:0]  BitCount
);

  localparam int            CW       = $clog2(MAX_BITS + 1);
  localparam logic [CW-1:0] MaxCount = CW'(MAX_BITS);

  state_e        state_q;
  logic [2:0]    residue_q, residue_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q;
  logic          bitReady_q;
  logic          outValid_q;
  logic          accept;

  mod3_step uStep (
    .rIn_i   (residue_q),
    .bitIn_i (BitIn),
    .rOut_o  (residue_d)
  );

  // Handshake uses the registered ready flag, so there is no path from
  // BitValid back to BitReady.
  assign accept = BitValid && bitReady_q;

  // Saturating bit counter; in practice the frame ends on reaching MaxCount,
  // the saturation only guarantees it can never wrap.
  always_comb begin
    count_d = count_q;
    if (count_q != MaxCount) begin
      count_d = count_q + CW'(1);
    end
  end

  // Frame controller. Ready/valid flags are kept as their own registers and
  // always move together with the state, so every output is a flop.
  always_ff @(posedge Clk) begin
    if (!RstN) begin
      state_q    <= ACCUM;
      residue_q  <= MOD3_ZERO;
      count_q    <= '0;
      err_q      <= 1'b0;
      bitReady_q <= 1'b1;
      outValid_q <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            residue_q <= residue_d;
            count_q   <= count_d;
            // The MAX_BITS-th bit closes the frame; it is only an error if
            // the sender did not mark it as the last one.
            if (BitLast || (count_d == MaxCount)) begin
              state_q    <= DONE;
              err_q      <= !BitLast;
              bitReady_q <= 1'b0;
              outValid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (OutReady) begin
            state_q    <= ACCUM;
            residue_q  <= MOD3_ZERO;
            count_q    <= '0;
            err_q      <= 1'b0;
            bitReady_q <= 1'b1;
            outValid_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= ACCUM;
          residue_q  <= MOD3_ZERO;
          count_q    <= '0;
          err_q      <= 1'b0;
          bitReady_q <= 1'b1;
          outValid_q <= 1'b0;
        end
      endcase
    end
  end

  assign BitReady = bitReady_q;
  assign OutValid = outValid_q;
  assign ModOut   = residue_q;
  assign OutErr   = err_q;
  assign BitCount = count_q;

endmodule

// File: tb/tb_mod3_serial_residue.sv
// tb_mod3_serial_residue
// Drives serial frames into mod3_serial_residue (MAX_BITS=4), predicts each
// frame result into a queue and compares it when the result is handed off.
module tb_mod3_serial_residue;

  localparam int MAX = 4;
  localparam int CW  = $clog2(MAX + 1);

  typedef struct {
    logic [2:0] modOut;
    logic       err;
    int         count;
  } result_t;

  logic          Clk;
  logic          RstN;
  logic          BitIn;
  logic          BitValid;
  logic          BitLast;
  logic          BitReady;
  logic [2:0]    ModOut;
  logic          OutValid;
  logic          OutReady;
  logic          OutErr;
  logic [CW-1:0] BitCount;

  int      testsRun;
  int      testsFailed;
  int      readyMode;
  bit      monitorOn;
  int      modelVal;
  int      modelCount;
  result_t expQ[$];
  result_t popped;

  mod3_serial_residue #(.MAX_BITS(MAX)) dut (
    .Clk      (Clk),
    .RstN     (RstN),
    .BitIn    (BitIn),
    .BitValid (BitValid),
    .BitLast  (BitLast),
    .BitReady (BitReady),
    .ModOut   (ModOut),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .OutErr   (OutErr),
    .BitCount (BitCount)
  );

  // 10 ns clock.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Offers one bit, waits for the block to be ready, and updates the
  // reference model on the accepting edge; a finished frame is queued.
  task automatic applyStimulus(input logic b, input logic last);
    int      waitCycles;
    result_t r;
    waitCycles = 0;
    BitIn    = b;
    BitLast  = last;
    BitValid = 1'b1;
    @(negedge Clk);
    while (!BitReady && waitCycles < 200) begin
      @(negedge Clk);
      waitCycles++;
    end
    checkOutput("bitAccepted", BitReady, 1);
    @(posedge Clk);
    modelVal   = (2 * modelVal + int'(b)) % 3;
    modelCount = modelCount + 1;
    if (last || modelCount == MAX) begin
      r.modOut = (modelVal == 0) ? 3'b001 : (modelVal == 1) ? 3'b010 : 3'b100;
      r.err    = !last;
      r.count  = modelCount;
      expQ.push_back(r);
      modelVal   = 0;
      modelCount = 0;
    end
    #1;
    BitValid = 1'b0;
    BitIn    = 1'b0;
    BitLast  = 1'b0;
  endtask

  // Waits until every predicted result has been consumed.
  task automatic waitDrain();
    int n;
    n = 0;
    while ((expQ.size() != 0 || OutValid) && n < 200) begin
      @(posedge Clk);
      #1;
      n++;
    end
    if (n == 200) checkOutput("drainTimeout", 1, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Consumer side: OutReady is changed a little after each edge according
  // to the mode chosen by the main sequence (1, 0 or random).
  always begin
    @(posedge Clk);
    #2;
    case (readyMode)
      0:       OutReady = 1'b1;
      1:       OutReady = 1'b0;
      default: OutReady = 1'($urandom_range(0, 1));
    endcase
  end

  // Mid-cycle monitor: invariants every cycle, and scoreboard compare on
  // each cycle where the result handshake is about to complete.
  always @(negedge Clk) begin
    if (monitorOn && RstN) begin
      checkOutput("oneHot", $countones(ModOut), 1);
      checkOutput("readyXorValid", BitReady ^ OutValid, 1);
      if (OutValid && OutReady) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedResult", 0, 1);
        end else begin
          popped = expQ.pop_front();
          checkOutput("modOut", ModOut, popped.modOut);
          checkOutput("outErr", OutErr, popped.err);
          checkOutput("bitCount", BitCount, popped.count);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: directed cases followed by random frames.
  initial begin
    int len;
    logic last;
    testsRun    = 0;
    testsFailed = 0;
    readyMode   = 0;
    monitorOn   = 1'b0;
    modelVal    = 0;
    modelCount  = 0;
    RstN        = 1'b0;
    BitIn       = 1'b0;
    BitValid    = 1'b0;
    BitLast     = 1'b0;
    OutReady    = 1'b0;

    @(posedge Clk);
    #1;
    @(negedge Clk);
    checkOutput("rstModOut", ModOut, 3'b001);
    checkOutput("rstBitCount", BitCount, 0);
    checkOutput("rstOutValid", OutValid, 0);
    checkOutput("rstOutErr", OutErr, 0);
    checkOutput("rstBitReady", BitReady, 1);
    @(posedge Clk);
    #1;
    RstN      = 1'b1;
    monitorOn = 1'b1;

    // Value 5: result one cycle after the last bit.
    applyStimulus(1, 0);
    applyStimulus(0, 0);
    applyStimulus(1, 1);
    checkOutput("v5OutValid", OutValid, 1);
    checkOutput("v5ModOut", ModOut, 3'b100);
    checkOutput("v5BitCount", BitCount, 3);
    checkOutput("v5OutErr", OutErr, 0);
    waitDrain();

    // Values 6 and 1 back to back.
    applyStimulus(1, 0);
    applyStimulus(1, 0);
    applyStimulus(0, 1);
    applyStimulus(1, 1);
    checkOutput("v1ModOut", ModOut, 3'b010);
    checkOutput("v1BitCount", BitCount, 1);
    waitDrain();

    // Value 7 with the consumer stalled; stray bits must be ignored.
    readyMode = 1;
    applyStimulus(1, 0);
    applyStimulus(1, 0);
    applyStimulus(1, 1);
    BitValid = 1'b1;
    BitIn    = 1'b1;
    BitLast  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      checkOutput("bpModOut", ModOut, 3'b010);
      checkOutput("bpOutValid", OutValid, 1);
      checkOutput("bpBitReady", BitReady, 0);
      checkOutput("bpBitCount", BitCount, 3);
    end
    @(posedge Clk);
    #1;
    BitValid  = 1'b0;
    BitIn     = 1'b0;
    BitLast   = 1'b0;
    readyMode = 0;
    waitDrain();

    // Forced termination at MAX bits: 1111 = 15.
    readyMode = 1;
    for (int i = 0; i < 4; i++) applyStimulus(1, 0);
    checkOutput("satOutValid", OutValid, 1);
    checkOutput("satModOut", ModOut, 3'b001);
    checkOutput("satOutErr", OutErr, 1);
    checkOutput("satBitCount", BitCount, 4);
    BitValid = 1'b1;
    BitIn    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      checkOutput("satHoldCount", BitCount, 4);
      checkOutput("satHoldReady", BitReady, 0);
    end
    @(posedge Clk);
    #1;
    BitValid  = 1'b0;
    BitIn     = 1'b0;
    readyMode = 0;
    waitDrain();
    checkOutput("postHsModOut", ModOut, 3'b001);
    checkOutput("postHsBitCount", BitCount, 0);
    checkOutput("postHsOutErr", OutErr, 0);
    checkOutput("postHsBitReady", BitReady, 1);
    applyStimulus(1, 1);
    waitDrain();

    // Reset in the middle of a frame discards it.
    applyStimulus(1, 0);
    applyStimulus(0, 0);
    RstN = 1'b0;
    @(posedge Clk);
    #1;
    modelVal   = 0;
    modelCount = 0;
    checkOutput("midRstModOut", ModOut, 3'b001);
    checkOutput("midRstBitCount", BitCount, 0);
    checkOutput("midRstOutValid", OutValid, 0);
    checkOutput("midRstBitReady", BitReady, 1);
    RstN = 1'b1;
    applyStimulus(1, 0);
    applyStimulus(0, 1);
    checkOutput("afterRstModOut", ModOut, 3'b100);
    waitDrain();

    // Random frames with random bit gaps and consumer stalls.
    readyMode = 2;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, MAX);
      for (int i = 0; i < len; i++) begin
        idle($urandom_range(0, 2));
        if (i == len - 1) last = (len == MAX) ? 1'($urandom_range(0, 1)) : 1'b1;
        else              last = 1'b0;
        applyStimulus(1'($urandom_range(0, 1)), last);
      end
    end
    waitDrain();
    readyMode = 0;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
